// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a ready/valid input and back-to-back frames.
// Define UART_TX_PARITY_EN to insert a parity bit (even/odd via PARITY_ODD).
module uart_tx_param #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 uart_tx,
  output logic                 busy,
  output logic                 tx_done
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
`ifdef UART_TX_PARITY_EN
  logic                 par_bit;
`endif

  logic accept, bit_end;
  assign accept  = s_valid && s_ready;
  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      uart_tx <= 1'b1;
      s_ready <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      if (state != IDLE) cnt <= bit_end ? '0 : cnt + 1'b1;
      // s_ready is only high in IDLE or the final stop cycle, so accept covers both entries to START
      if (accept) begin
        state   <= START;
        shreg   <= s_data;
        bit_idx <= '0;
        uart_tx <= 1'b0;
        busy    <= 1'b1;
        s_ready <= 1'b0;
`ifdef UART_TX_PARITY_EN
        par_bit <= (^s_data) ^ (PARITY_ODD != 0);
`endif
      end else begin
        case (state)
          IDLE: ;
          START: if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            uart_tx <= shreg[0];
            shreg   <= shreg >> 1;
          end
          DATA: if (bit_end) begin
            if (bit_idx == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              uart_tx <= par_bit;
`else
              state   <= STOP;
              uart_tx <= 1'b1;
              bit_idx <= '0;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              uart_tx <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: if (bit_end) begin
            state   <= STOP;
            uart_tx <= 1'b1;
            bit_idx <= '0;
          end
`endif
          STOP: begin
            // registered outputs: raise done/ready one cycle early so they line up with the last stop cycle
            if (bit_idx == STOP_LAST && cnt == CNT_PRE) begin
              tx_done <= 1'b1;
              s_ready <= 1'b1;
            end
            if (bit_end) begin
              if (bit_idx != STOP_LAST) begin
                bit_idx <= bit_idx + 1'b1;
              end else begin
                state   <= IDLE;
                bit_idx <= '0;
                busy    <= 1'b0;
                uart_tx <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// Randomised bench for uart_tx_param; a frame-level reference model predicts every output each cycle.
module tb_uart_tx_param;
  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int CPB    = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int DB = 7, SB = 2, PODD = 1, P = 1;
`else
  localparam int DB = 8, SB = 1, PODD = 0, P = 0;
`endif
  localparam int NB    = 1 + DB + P + SB;
  localparam int FRAME = NB * CPB;

  logic          clk = 1'b0, rst_n = 1'b1, s_valid = 1'b0;
  logic [DB-1:0] s_data = '0;
  logic          s_ready, uart_tx, busy, tx_done;
  int            total = 0, bad = 0;

  uart_tx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(PODD)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .uart_tx(uart_tx), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame as a list of line bits: start, data LSB first, optional parity, stop bits
  function automatic logic [NB-1:0] mk(input logic [DB-1:0] d);
    logic [NB-1:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DB; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    f[1+DB] = (^d) ^ (PODD != 0);
`endif
    return f;
  endfunction

  // pos = cycle index within the current frame, -1 when idle
  int            pos = -1, cyc = 0, acc_cyc = 0, m_acc = 0;
  logic [NB-1:0] fbits = '1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pos <= -1;
    else begin
      cyc <= cyc + 1;
      if ((pos < 0 || pos == FRAME-1) && s_valid) begin
        fbits   <= mk(s_data);
        pos     <= 0;
        acc_cyc <= cyc + 1;
        m_acc   <= m_acc + 1;
      end else if (pos == FRAME-1) pos <= -1;
      else if (pos >= 0) pos <= pos + 1;
    end
  end

  bit mon_en = 1'b0;
  always @(negedge clk) if (mon_en) begin
    chk("line",  {31'b0, uart_tx}, (pos < 0) ? 32'd1 : {31'b0, fbits[pos/CPB]});
    chk("busy",  {31'b0, busy},    {31'b0, pos >= 0});
    chk("ready", {31'b0, s_ready}, {31'b0, (pos < 0) || (pos == FRAME-1)});
    chk("done",  {31'b0, tx_done}, {31'b0, pos == FRAME-1});
    // a transfer in the done cycle lands exactly FRAME edges after the previous one
    if (tx_done === 1'b1) chk("done_lat", cyc + 1 - acc_cyc, FRAME);
  end

  // Called at a negedge; returns at the negedge after the word is accepted
  task automatic send(input logic [DB-1:0] w, input bit keep);
    int a0, n;
    a0 = m_acc;
    n  = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (m_acc == a0 && n < 4*FRAME) begin
      @(negedge clk);
      n++;
    end
    if (m_acc == a0) chk("accept_timeout", 0, 1);
    if (!keep) s_valid = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_line", {31'b0, uart_tx}, 1);
    chk("rst_ready", {31'b0, s_ready}, 1);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    send(DB'(8'hA5), 1'b0);
    repeat (FRAME + 5) @(negedge clk);

    send(DB'(8'h55), 1'b1);
    send(DB'(8'h0F), 1'b0);
    repeat (FRAME + 5) @(negedge clk);

    send(DB'(8'h03), 1'b0);
    repeat (FRAME + 5) @(negedge clk);

    // data changes after acceptance must not reach the line; valid mid-frame waits for the last stop cycle
    send(DB'(8'h3C), 1'b0);
    repeat (30) begin
      @(negedge clk);
      s_data = DB'($urandom);
    end
    send(DB'($urandom), 1'b0);
    repeat (FRAME + 5) @(negedge clk);

    // reset mid-frame
    send(DB'(8'h5A), 1'b0);
    repeat (44) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_line",  {31'b0, uart_tx}, 1);
    chk("mid_rst_ready", {31'b0, s_ready}, 1);
    chk("mid_rst_busy",  {31'b0, busy},    0);
    chk("mid_rst_done",  {31'b0, tx_done}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send(DB'(8'h81), 1'b0);
    repeat (FRAME + 5) @(negedge clk);

    for (int k = 0; k < 25; k++) begin
      bit keep;
      keep = ($urandom_range(0, 2) == 0);
      send(DB'($urandom), keep);
      if (!keep) begin
        repeat ($urandom_range(0, FRAME + 20)) begin
          @(negedge clk);
          s_data = DB'($urandom);
        end
      end
    end
    s_valid = 1'b0;
    repeat (FRAME + 5) @(negedge clk);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised UART transmitter, the successor to the fixed 8N1 byte transmitter.
- Adds the following over its predecessor:
  - generic clock and baud rate;
  - 5–9 data bits and 1 or 2 stop bits;
  - ready/valid input handshake with gapless back-to-back frames;
  - optional parity.
- Sits between a byte/word producer (CORDIC result formatter, FIFO) and the board TX pin.

Parameters:
- CLK_HZ, 50000000: system clock frequency in Hz.
- BAUD, 115200: line rate. CLKS_PER_BIT = CLK_HZ/BAUD (integer truncation), must be ≥ 2.
- DATA_BITS, 8: payload width. Legal range 5..9.
- STOP_BITS, 1: stop bit count. Legal values 1 or 2.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Used only when UART_TX_PARITY_EN is defined.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_data  input  DATA_BITS  word to send; bit 0 is sent first.
- s_valid  input  1  producer has a word.
- s_ready  output  1  block can accept a word this cycle.
- uart_tx  output  1  serial line, idles high. Registered output.
- busy  output  1  high while a frame is on the line.
- tx_done  output  1  one-cycle pulse in the final cycle of the last stop bit.

Behaviour:
- Reset values: uart_tx=1, s_ready=1, busy=0, tx_done=0; FSM in IDLE; bit-period counter and bit index = 0.
- Reset is asynchronous and may be asserted mid-frame. The line returns high immediately and the partial frame is abandoned; no tx_done is produced.
- Handshake:
  - A transfer occurs on a rising edge where s_valid && s_ready.
  - s_data is latched into a shift register at that edge; later changes on s_data have no effect.
  - s_valid may be asserted independently of s_ready. Nothing is accepted while s_ready=0.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE, or STOP → START when back-to-back.
  - IDLE: uart_tx=1, s_ready=1, busy=0. A transfer moves the FSM to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: DATA_BITS bits, LSB first, each held for CLKS_PER_BIT cycles. The bit index counts 0..DATA_BITS-1.
  - PARITY: present only with the macro; one bit period.
  - STOP: uart_tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Timing:
  - The first start-bit cycle is the cycle after the transfer edge; uart_tx falls at the transfer edge + 1.
  - Every bit lasts exactly CLKS_PER_BIT cycles, with no drift across the frame.
  - The bit-period counter runs 0..CLKS_PER_BIT-1 and wraps to 0 at the bit boundary. It is held at 0 in IDLE.
- Frame end:
  - In the final cycle of the last stop bit, tx_done=1 and s_ready=1.
  - A transfer in that cycle goes straight to START, giving no idle gap. Frame period = (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT, where P = 1 with parity and 0 without.
  - Without a transfer in that cycle, the FSM goes to IDLE.
- busy is high from the cycle after the transfer through the last stop-bit cycle. It stays high continuously across back-to-back frames.
- s_ready is low for every cycle of START/DATA/PARITY/STOP except the final stop-bit cycle.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - A parity bit is inserted after the data bits.
  - Even mode (PARITY_ODD=0): parity = XOR of the data bits.
  - Odd mode (PARITY_ODD=1): parity = the inverse of that XOR.
- Not defined: no PARITY state or logic exists; PARITY_ODD is ignored; P=0.

Test Plan (CLK_HZ=1000000, BAUD=100000 → 10 clk/bit):
- Reset, then 20 idle cycles → uart_tx=1, s_ready=1, busy=0, tx_done=0 throughout.
- 8N1, send 0xA5 → uart_tx low for 10 clks, then bits 1,0,1,0,0,1,0,1 at 10 clks each, then high. tx_done pulses once, exactly 100 clks after the transfer edge.
- s_valid held with 0x55 then 0x0F, back-to-back → second start bit begins on the cycle after the first frame's last stop cycle. busy never drops; tx_done pulses twice, 100 clks apart.
- DATA_BITS=7, STOP_BITS=2, macro on, PARITY_ODD=1, send 7'h03 → frame is 110 clks; parity bit = 1; stop high for 20 clks.
- Change s_data mid-frame after accepting 0x3C → transmitted bits still match 0x3C. s_valid asserted mid-frame is not accepted until the final stop cycle.
- Assert rst_n low at clk 45 of a frame → uart_tx=1 immediately, s_ready=1, no tx_done. A fresh 0x81 frame after release is correct.
